// File: rtl/alu_arb.sv
// alu_arb: two-requester round-robin front end for one shared combinational ALU.
// Defining ALU_ARB_STATS_EN adds saturating per-requester grant counters.
module alu_arb #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [3:0]        req_cntrl0,
  input  logic [3:0]        req_cntrl1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        req_ready,
  output logic [3:0]        alu_cntrl,
  output logic [DATA_W-1:0] alu_d1,
  output logic [DATA_W-1:0] alu_d2,
  input  logic [DATA_W-1:0] alu_output,
  input  logic              alu_zero,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  input  logic              resp_ready,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef struct packed {
    logic [3:0]        cntrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              id;
  } op_t;

  state_e            state_q, state_d;
  op_t               op_q, op_d;
  op_t               req_op [2];
  logic              last_q, last_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic              resp_zero_q, resp_zero_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [1:0]        grant;
  logic              hs;
  logic              gsel;

  assign req_op[0] = '{cntrl: req_cntrl0, a: req_a0, b: req_b0, id: 1'b0};
  assign req_op[1] = '{cntrl: req_cntrl1, a: req_a1, b: req_b1, id: 1'b1};

  // Tie goes to whichever requester was not granted last; rst gates the strobe
  // so nothing is offered while reset is held.
  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE && rst) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign hs        = |grant;
  assign gsel      = grant[1];
  assign req_ready = grant;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    last_d       = last_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_zero_d  = resp_zero_q;
    resp_data_d  = resp_data_q;
    alu_cntrl    = '0;
    alu_d1       = '0;
    alu_d2       = '0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          op_d    = req_op[gsel];
          last_d  = gsel;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_cntrl    = op_q.cntrl;
        alu_d1       = op_q.a;
        alu_d2       = op_q.b;
        resp_data_d  = alu_output;
        resp_zero_d  = alu_zero;
        resp_id_d    = op_q.id;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        // ALU ports keep the captured operands so the result stays consistent
        alu_cntrl = op_q.cntrl;
        alu_d1    = op_q.a;
        alu_d2    = op_q.b;
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      last_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_zero_q  <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      last_q       <= last_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_zero_q  <= resp_zero_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_zero  = resp_zero_q;
  assign resp_data  = resp_data_q;

`ifdef ALU_ARB_STATS_EN
  logic [1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (grant[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb: random requesters plus directed scenarios,
// checked against a transaction-level model of the arbiter.
module tb_alu_arb;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready;
  logic [3:0]   req_cntrl0, req_cntrl1, alu_cntrl;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1, alu_d1, alu_d2, alu_output, resp_data;
  logic         alu_zero, resp_valid, resp_id, resp_zero, resp_ready;
  logic [15:0]  grant_cnt0, grant_cnt1;

  always #5 clk = ~clk;

  alu_arb #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_cntrl0(req_cntrl0), .req_cntrl1(req_cntrl1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ready(req_ready), .alu_cntrl(alu_cntrl), .alu_d1(alu_d1), .alu_d2(alu_d2),
    .alu_output(alu_output), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_ready(resp_ready),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // Stand-in for the shared ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, else pass a.
  function automatic logic [W-1:0] alu_f(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  always_comb begin
    alu_output = alu_f(alu_cntrl, alu_d1, alu_d2);
    alu_zero   = (alu_output == '0);
  end

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: busy from grant until the response is taken.
  bit          m_busy = 0;
  int          m_age = 0;
  bit          m_last = 1;
  int          m_cnt[2] = '{0, 0};
  logic [1:0]  hs_last = 2'b00;
  bit          bp_prev = 0;
  logic [W-1:0] s_data;
  logic        s_id, s_zero;
  logic [67:0] s_alu;

  always @(negedge clk) begin
    logic [1:0] eg;
    exp_t       e, got;
    logic       gid;
    if (!rst) begin
      m_busy = 0; m_age = 0; m_last = 1; m_cnt = '{0, 0};
      sb.delete(); bp_prev = 0; hs_last = 2'b00;
      chk("rst_req_ready", 128'(req_ready), 128'd0);
      chk("rst_resp_valid", 128'(resp_valid), 128'd0);
      chk("rst_alu_ports", 128'({alu_cntrl, alu_d1, alu_d2}), 128'd0);
    end else begin
      eg = 2'b00;
      if (!m_busy) begin
        if (req_valid == 2'b01) eg = 2'b01;
        else if (req_valid == 2'b10) eg = 2'b10;
        else if (req_valid == 2'b11) eg = m_last ? 2'b01 : 2'b10;
      end
      chk("req_ready", 128'(req_ready), 128'(eg));
      chk("resp_valid", 128'(resp_valid), 128'(m_busy && m_age >= 1));
      if (!m_busy) chk("alu_idle_zero", 128'({alu_cntrl, alu_d1, alu_d2}), 128'd0);
`ifdef ALU_ARB_STATS_EN
      chk("grant_cnt0", 128'(grant_cnt0), 128'((m_cnt[0] > 65535) ? 65535 : m_cnt[0]));
      chk("grant_cnt1", 128'(grant_cnt1), 128'((m_cnt[1] > 65535) ? 65535 : m_cnt[1]));
`else
      chk("grant_cnt_tied", 128'({grant_cnt0, grant_cnt1}), 128'd0);
`endif
      if (bp_prev) begin
        chk("bp_resp_stable", 128'({resp_id, resp_zero, resp_data}), 128'({s_id, s_zero, s_data}));
        chk("bp_alu_stable", 128'({alu_cntrl, alu_d1, alu_d2}), 128'(s_alu));
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 128'(resp_valid), 128'd0);
        end else begin
          e = sb.pop_front();
          got = '{id: resp_id, data: resp_data, zero: resp_zero};
          chk("resp_id", 128'(got.id), 128'(e.id));
          chk("resp_data", 128'(got.data), 128'(e.data));
          chk("resp_zero", 128'(got.zero), 128'(e.zero));
        end
      end
      hs_last = req_valid & req_ready;
      if (m_busy) begin
        if (m_age >= 1 && resp_ready) m_busy = 0;
        else m_age++;
      end else if (eg != 2'b00) begin
        gid = eg[1];
        e.id   = gid;
        e.data = gid ? alu_f(req_cntrl1, req_a1, req_b1) : alu_f(req_cntrl0, req_a0, req_b0);
        e.zero = (e.data == '0);
        sb.push_back(e);
        m_busy = 1; m_age = 0; m_last = gid;
        m_cnt[gid]++;
      end
      bp_prev = resp_valid && !resp_ready;
      s_data = resp_data; s_id = resp_id; s_zero = resp_zero;
      s_alu = {alu_cntrl, alu_d1, alu_d2};
    end
  end

  task automatic set_op(int i, logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    if (i == 0) begin req_cntrl0 = c; req_a0 = a; req_b0 = b; end
    else        begin req_cntrl1 = c; req_a1 = a; req_b1 = b; end
  endtask

  task automatic rand_op(int i);
    logic [W-1:0] a;
    logic [3:0]   c;
    a = $urandom;
    c = 4'($urandom_range(0, 6));
    // sub/xor with b == a exercises the zero flag regularly
    if ($urandom_range(0, 4) == 0) set_op(i, ($urandom_range(0, 1) != 0) ? 4'd1 : 4'd4, a, a);
    else set_op(i, c, a, $urandom);
  endtask

  task automatic quiesce();
    req_valid = 2'b00; resp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic single(int i, logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b,
                        logic [W-1:0] ed, logic ez);
    set_op(i, c, a, b);
    req_valid = (i == 0) ? 2'b01 : 2'b10;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 128'(req_ready), 128'(req_valid));
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk("single_exec_no_resp", 128'(resp_valid), 128'd0);
    @(negedge clk);
    chk("single_resp_valid", 128'(resp_valid), 128'd1);
    chk("single_resp", 128'({resp_id, resp_zero, resp_data}), 128'({i[0], ez, ed}));
    @(posedge clk); #1;
  endtask

  initial begin
    int grants[$];
    int gcyc[$];
    int cyc;
    rst = 1'b0; req_valid = 2'b00; resp_ready = 1'b1;
    set_op(0, 4'd0, '0, '0); set_op(1, 4'd0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single request and zero flag
    single(0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0);
    single(1, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    single(0, 4'd9, 32'hDEAD_BEEF, 32'd3, 32'hDEAD_BEEF, 1'b0);

    // Tie after reset: 0,1,0,1 every 3 cycles
    quiesce(); do_reset();
    req_valid = 2'b11; resp_ready = 1'b1;
    set_op(0, 4'd2, 32'hF0F0, 32'hFF00); set_op(1, 4'd3, 32'h1, 32'h2);
    cyc = 0;
    repeat (13) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin grants.push_back(int'(req_ready[1])); gcyc.push_back(cyc); end
      cyc++;
    end
    chk("tie_grant_count", 128'(grants.size() >= 4), 128'd1);
    if (grants.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("tie_order_%0d", k), 128'(grants[k]), 128'(k % 2));
      for (int k = 1; k < 4; k++) chk($sformatf("tie_gap_%0d", k), 128'(gcyc[k] - gcyc[k-1]), 128'd3);
    end

    // Backpressure with the other requester waiting
    quiesce();
    set_op(0, 4'd1, 32'd100, 32'd58);
    req_valid = 2'b01; resp_ready = 1'b0;
    @(posedge clk); #1;
    set_op(1, 4'd0, 32'd1, 32'd1);
    req_valid = 2'b10;
    @(negedge clk); @(negedge clk);
    chk("bp_resp_data", 128'({resp_valid, resp_id, resp_data}), 128'({1'b1, 1'b0, 32'd42}));
    repeat (5) @(negedge clk);
    chk("bp_req_ready", 128'(req_ready), 128'd0);
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_grant", 128'(req_ready), 128'd2);

    // Reset in EXEC discards the operation
    quiesce();
    set_op(1, 4'd0, 32'd9, 32'd9);
    req_valid = 2'b10;
    @(posedge clk); #1 req_valid = 2'b00;
    rst = 1'b0;
    #1 chk("rst_exec_resp_valid", 128'(resp_valid), 128'd0);
    @(posedge clk); #1 rst = 1'b1;
    cyc = 0;
    repeat (4) begin @(negedge clk); if (resp_valid) cyc++; end
    chk("rst_exec_no_resp", 128'(cyc), 128'd0);
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk);
    chk("rst_exec_tie_first", 128'(req_ready), 128'd1);

    // Statistics: three grants to requester 1
    quiesce(); do_reset();
    for (int k = 0; k < 3; k++) single(1, 4'd4, 32'(k), 32'd3, 32'(k) ^ 32'd3, 1'b0);
`ifdef ALU_ARB_STATS_EN
    chk("stats_cnt", 128'({grant_cnt0, grant_cnt1}), 128'({16'd0, 16'd3}));
`else
    chk("stats_cnt", 128'({grant_cnt0, grant_cnt1}), 128'd0);
`endif

    // Random traffic
    quiesce();
    repeat (1500) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (hs_last[i]) begin
          if ($urandom_range(0, 3) == 0) req_valid[i] = 1'b0;
          else rand_op(i);
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          rand_op(i); req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 40) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    quiesce();
    chk("sb_drained", 128'(sb.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
